bf_job_scheduler: RTL
=====================

Name: bf_job_scheduler

Overview:
- Top-level sequencer for the 32x32 Bellman-Ford processing block.
- Arbitrates the shared 1024-word distance/adjacency memory between a host loader and the processing block.
- Resets and starts the processing block, watches its finish flag with a watchdog, drains trailing writes and returns results to the host over a four-phase job handshake.

Parameters:
- ADDR_W, 10, memory address width; matches the processing block's read/write address ports.
- DRAIN_CYC, 4, cycles waited after pb_finish for in-flight datapath writes; legal range 1..15.
- TIMEOUT, 20'd1000000, RUN-state cycle limit before watchdog abort; must be >= 1.
- CYC_W, 24, width of cycle_count.

Ports:
- clk  in  1  system clock.
- rst_global  in  1  reset; asynchronous assert, active-low.
- host_load_req  in  1  host requests memory ownership for loading.
- host_load_done  in  1  one-cycle pulse; host finished loading.
- job_req  in  1  four-phase job request level.
- job_ack  out  1  four-phase acknowledge level.
- abort  in  1  host abort of a running job.
- pb_rst  out  1  active-high reset to the processing block.
- pb_start  out  1  one-cycle start pulse to the processing block.
- pb_finish  in  1  processing block finish flag (level).
- mem_owner  out  1  memory mux select: 0 = host, 1 = processing block.
- busy  out  1  high in CLEAR, RUN and DRAIN.
- timeout_err  out  1  sticky; last job hit the watchdog.
- aborted  out  1  sticky; last job was aborted.
- cycle_count  out  CYC_W  RUN-state cycles of the last or current job.
- job_count  out  8  completed jobs, wraps.

Behaviour:
- Reset (rst_global=0, asynchronous): state=IDLE; all outputs 0.
- Reset mid-job: state returns to IDLE immediately and mem_owner drops to 0 (host); pb_rst is not asserted by reset itself.
- Moore FSM, all outputs registered.
- States: IDLE, LOAD, CLEAR, RUN, DRAIN, DONE.
- IDLE: mem_owner=0.
  - host_load_req=1 -> LOAD. Loading has priority when host_load_req and job_req rise together.
  - Otherwise job_req=1 -> CLEAR.
- LOAD: mem_owner=0.
  - Stays until host_load_done=1, then -> IDLE.
  - job_req is ignored here.
- CLEAR:
  - mem_owner=1; pb_rst=1 for exactly 2 cycles.
  - timeout_err, aborted and cycle_count are cleared on entry.
  - Then -> RUN.
- RUN:
  - pb_start=1 on the first RUN cycle only.
  - cycle_count increments each RUN cycle and saturates at all-ones.
  - pb_finish is ignored on the first RUN cycle, so a stale flag cannot end the job.
  - Exit priority, highest first:
    1. abort=1 -> aborted=1, pb_rst=1 for one cycle, -> DONE.
    2. Watchdog (RUN cycle count == TIMEOUT) -> timeout_err=1, -> DONE.
    3. pb_finish=1 -> DRAIN.
- DRAIN: mem_owner stays 1; counts DRAIN_CYC cycles, then -> DONE.
- DONE:
  - mem_owner=0; job_ack=1.
  - job_count increments once on entry, for a normal finish only.
  - Waits for job_req=0, then job_ack=0 -> IDLE.
- Handshake:
  - job_ack never rises before the job ends.
  - A new job is never accepted while job_ack=1.
- abort outside RUN has no effect.
- host_load_done outside LOAD has no effect.
- Latency, job_req rise to pb_start: 4 cycles (IDLE sample, CLEAR x2, RUN entry).
- Latency, pb_finish to job_ack: DRAIN_CYC+1 cycles.
- mem_owner changes only on FSM state edges and never toggles within a cycle of pb_start.

Optional Feature:
- Macro: BF_PERF_CNT_EN.
- Defined: cycle_count and job_count are implemented as specified.
- Undefined: both counter registers are removed and the outputs are tied to 0.
- FSM, watchdog and all other outputs are identical in both builds. The watchdog counter is kept as a separate internal counter.

Test Plan:
- Reset: hold rst_global=0 with job_req=1 -> all outputs 0, state IDLE. Release reset -> pb_start is seen 4 cycles later.
- Normal job: load (host_load_req, then host_load_done) -> mem_owner stays 0; job_req=1; pb_finish rises after 200 RUN cycles.
  - Required: job_ack rises DRAIN_CYC+1=5 cycles after pb_finish.
  - Required: cycle_count=200, job_count=1, mem_owner=0 in DONE.
  - Drop job_req -> job_ack drops -> IDLE.
- Watchdog: TIMEOUT=50, pb_finish held 0 -> after 50 RUN cycles timeout_err=1, job_ack=1, job_count unchanged.
- Abort: abort=1 at RUN cycle 10 -> aborted=1, one-cycle pb_rst pulse, DONE next cycle. A subsequent job clears aborted in CLEAR.
- Abort and pb_finish in the same cycle -> aborted=1, no DRAIN, job_count unchanged.
- Stale finish and arbitration:
  - pb_finish=1 already high at RUN entry -> ignored for the first cycle; DRAIN entered on the second RUN cycle.
  - host_load_req and job_req rising in the same cycle -> LOAD taken first, job starts after host_load_done.
- Build without BF_PERF_CNT_EN -> cycle_count=0 and job_count=0 throughout; all other timing identical.

Source files
------------

// File: rtl/bf_job_scheduler.sv
// Job sequencer for the 32x32 Bellman-Ford block: memory arbitration, PB reset/start,
// watchdog, drain and four-phase host handshake. BF_PERF_CNT_EN enables cycle/job counters.
module bf_job_scheduler #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DRAIN_CYC = 4,
  parameter logic [19:0] TIMEOUT   = 20'd1000000,
  parameter int unsigned CYC_W     = 24
) (
  input  logic             clk,
  input  logic             rst_global,
  input  logic             host_load_req,
  input  logic             host_load_done,
  input  logic             job_req,
  output logic             job_ack,
  input  logic             abort,
  output logic             pb_rst,
  output logic             pb_start,
  input  logic             pb_finish,
  output logic             mem_owner,
  output logic             busy,
  output logic             timeout_err,
  output logic             aborted,
  output logic [CYC_W-1:0] cycle_count,
  output logic [7:0]       job_count
);

  if (ADDR_W == 0 || DRAIN_CYC < 1 || DRAIN_CYC > 15 || TIMEOUT == '0) begin : g_param_check
    $error("bf_job_scheduler: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        clr_q, clr_d;
  logic [3:0]  drn_q, drn_d;
  logic [19:0] wd_q, wd_d;
  logic        pb_rst_q, pb_rst_d;
  logic        pb_start_q, pb_start_d;
  logic        mem_owner_q, mem_owner_d;
  logic        busy_q, busy_d;
  logic        job_ack_q, job_ack_d;
  logic        timeout_err_q, timeout_err_d;
  logic        aborted_q, aborted_d;

  always_comb begin
    state_d       = state_q;
    clr_d         = clr_q;
    drn_d         = drn_q;
    wd_d          = wd_q;
    pb_rst_d      = 1'b0;
    pb_start_d    = 1'b0;
    mem_owner_d   = mem_owner_q;
    busy_d        = busy_q;
    job_ack_d     = job_ack_q;
    timeout_err_d = timeout_err_q;
    aborted_d     = aborted_q;
    unique case (state_q)
      S_IDLE: begin
        if (host_load_req) begin
          state_d = S_LOAD;
        end else if (job_req) begin
          state_d       = S_CLEAR;
          clr_d         = 1'b0;
          pb_rst_d      = 1'b1;
          mem_owner_d   = 1'b1;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          aborted_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (host_load_done) state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (!clr_q) begin
          clr_d    = 1'b1;
          pb_rst_d = 1'b1;
        end else begin
          state_d    = S_RUN;
          pb_start_d = 1'b1;
          wd_d       = 20'd1;
        end
      end
      S_RUN: begin
        wd_d = wd_q + 20'd1;
        if (abort) begin
          // Abort leaves via DONE with a one-cycle PB reset overlapping the first DONE cycle
          state_d     = S_DONE;
          aborted_d   = 1'b1;
          pb_rst_d    = 1'b1;
          mem_owner_d = 1'b0;
          busy_d      = 1'b0;
          job_ack_d   = 1'b1;
        end else if (wd_q == TIMEOUT) begin
          state_d       = S_DONE;
          timeout_err_d = 1'b1;
          mem_owner_d   = 1'b0;
          busy_d        = 1'b0;
          job_ack_d     = 1'b1;
        end else if (pb_finish && !pb_start_q) begin
          // pb_start_q marks the first RUN cycle, where a stale finish flag is ignored
          state_d = S_DRAIN;
          drn_d   = 4'd0;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 4'd1;
        if (drn_q == 4'(DRAIN_CYC - 1)) begin
          state_d     = S_DONE;
          mem_owner_d = 1'b0;
          busy_d      = 1'b0;
          job_ack_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (!job_req) begin
          state_d   = S_IDLE;
          job_ack_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_global) begin
    if (!rst_global) begin
      state_q       <= S_IDLE;
      clr_q         <= 1'b0;
      drn_q         <= '0;
      wd_q          <= '0;
      pb_rst_q      <= 1'b0;
      pb_start_q    <= 1'b0;
      mem_owner_q   <= 1'b0;
      busy_q        <= 1'b0;
      job_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_q         <= clr_d;
      drn_q         <= drn_d;
      wd_q          <= wd_d;
      pb_rst_q      <= pb_rst_d;
      pb_start_q    <= pb_start_d;
      mem_owner_q   <= mem_owner_d;
      busy_q        <= busy_d;
      job_ack_q     <= job_ack_d;
      timeout_err_q <= timeout_err_d;
      aborted_q     <= aborted_d;
    end
  end

`ifdef BF_PERF_CNT_EN
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic [7:0]       job_count_q, job_count_d;

  // cycle_count shows k during RUN cycle k; only a DRAIN->DONE exit is a completed job
  always_comb begin
    cycle_count_d = cycle_count_q;
    job_count_d   = job_count_q;
    if (state_q == S_IDLE && state_d == S_CLEAR) begin
      cycle_count_d = '0;
    end else if (state_d == S_RUN && cycle_count_q != '1) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end
    if (state_q == S_DRAIN && state_d == S_DONE) begin
      job_count_d = job_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_global) begin
    if (!rst_global) begin
      cycle_count_q <= '0;
      job_count_q   <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      job_count_q   <= job_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign job_count   = job_count_q;
`else
  assign cycle_count = '0;
  assign job_count   = '0;
`endif

  assign pb_rst      = pb_rst_q;
  assign pb_start    = pb_start_q;
  assign mem_owner   = mem_owner_q;
  assign busy        = busy_q;
  assign job_ack     = job_ack_q;
  assign timeout_err = timeout_err_q;
  assign aborted     = aborted_q;

endmodule
